// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the HEX display scheduler.
// Holds the segment type, the dark pattern, the FSM encoding and the round-robin search.
package hex_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t    BLANK_SEG = 7'h7F;
  localparam int       MAX_REQ   = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHOW = 1'b1} state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping at nreq.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0] ptr,
                                       input int nreq);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= nreq) k = k - nreq;
      if (i < nreq && !r.found && req[k[2:0]]) begin
        r.found = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_display_scheduler_seven_hex_decoder.sv
// SevenHexDecoder: 0..15 to a tens/ones digit pair, active-low segments.
// Bit 0 is segment a, bit 6 is segment g.
module SevenHexDecoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg7_t      o_seven_ten,
  output seg7_t      o_seven_one
);

  logic [3:0] ones;

  function automatic seg7_t digit(input logic [3:0] d);
    case (d)
      4'd0:    digit = 7'b1000000;
      4'd1:    digit = 7'b1111001;
      4'd2:    digit = 7'b0100100;
      4'd3:    digit = 7'b0110000;
      4'd4:    digit = 7'b0011001;
      4'd5:    digit = 7'b0010010;
      4'd6:    digit = 7'b0000010;
      4'd7:    digit = 7'b1111000;
      4'd8:    digit = 7'b0000000;
      4'd9:    digit = 7'b0010000;
      default: digit = BLANK_SEG;
    endcase
  endfunction

  always_comb begin
    if (i_hex >= 4'd10) begin
      o_seven_ten = digit(4'd1);
      ones        = i_hex - 4'd10;
    end else begin
      o_seven_ten = digit(4'd0);
      ones        = i_hex;
    end
    o_seven_one = digit(ones);
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares one two-digit HEX pair between NREQ requesters: round-robin grants held
// for at least DWELL_CYC cycles, owner's value decoded and registered to the pins.
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int    NREQ      = 3,
  parameter int    DWELL_CYC = 50_000_000,
  parameter seg7_t BLANK     = BLANK_SEG
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*4-1:0]       i_val,
  input  logic                    i_blank,
  output logic [NREQ-1:0]         o_ack,
  output logic [$clog2(NREQ)-1:0] o_owner,
  output logic                    o_busy,
  output seg7_t                   o_seven_ten,
  output seg7_t                   o_seven_one
);

  localparam int OW = $clog2(NREQ);
  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam logic [DW-1:0] DW_RELOAD = DW'(DWELL_CYC - 1);

  logic [0:0]             state_q;
  logic [OW-1:0]          rr_ptr_q;
  logic [DW-1:0]          dwell_q;
  logic [3:0]             val_q;
  logic [NREQ-1:0][3:0]   val_arr;
  logic [NREQ-1:0]        req_cand;
  rr_pick_t               pick;
  logic                   grant;
  logic [OW-1:0]          grant_idx;
  logic [OW-1:0]          grant_nxt;
  seg7_t                  dec_ten;
  seg7_t                  dec_one;
  logic                   unused_pick;

  assign val_arr = i_val;
  assign o_busy  = (state_q == ST_SHOW);

  // While showing, the current owner is excluded so a waiting requester always wins.
  always_comb begin
    req_cand = i_req;
    if (state_q == ST_SHOW) req_cand[o_owner] = 1'b0;
  end

  assign pick        = rr_next(MAX_REQ'(req_cand), 3'(rr_ptr_q), NREQ);
  assign grant       = pick.found && (state_q == ST_IDLE || dwell_q == '0);
  assign grant_idx   = pick.idx[OW-1:0];
  assign grant_nxt   = (grant_idx == OW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign unused_pick = ^pick.idx;

  SevenHexDecoder u_dec (
    .i_hex       (val_q),
    .o_seven_ten (dec_ten),
    .o_seven_one (dec_one)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      dwell_q     <= '0;
      val_q       <= '0;
      o_ack       <= '0;
      o_owner     <= '0;
      o_seven_ten <= BLANK;
      o_seven_one <= BLANK;
    end else begin
      o_ack <= '0;
      if (state_q == ST_SHOW && !i_blank) begin
        o_seven_ten <= dec_ten;
        o_seven_one <= dec_one;
      end else begin
        o_seven_ten <= BLANK;
        o_seven_one <= BLANK;
      end

      if (state_q == ST_SHOW) begin
        if (i_req[o_owner]) val_q <= val_arr[o_owner];
        if (dwell_q != '0) begin
          dwell_q <= dwell_q - 1'b1;
        end else if (!grant) begin
          if (i_req[o_owner]) dwell_q <= DW_RELOAD;
          else                state_q <= ST_IDLE;
        end
      end

      // A grant overrides the live-update above with the new owner's value.
      if (grant) begin
        state_q  <= ST_SHOW;
        o_owner  <= grant_idx;
        rr_ptr_q <= grant_nxt;
        dwell_q  <= DW_RELOAD;
        val_q    <= val_arr[grant_idx];
        o_ack    <= NREQ'(1) << grant_idx;
      end
    end
  end

endmodule
